// File: rtl/icache_refill_unit.sv
// icache_refill_unit: services L1 instruction-cache misses by fetching one aligned
// block from the next memory level and streaming its words into the selected set.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-low reset
//   instr_hit_f_i           controller hit indication (0 = miss)
//   ic_repl_permit_i        replacement permitted this cycle
//   pc_f_i                  fetch address of the missing instruction
//   abort_i                 fetch redirect, cancels the in-flight refill
//   mem_req_o/mem_addr_o    block read request and block-aligned address
//   mem_ready_i             memory accepts the request
//   mem_rvalid_i/rdata_i    read data beats
//   refill_we_o             write one word into the cache
//   refill_set_o/word_o     target set and word offset
//   refill_data_o/tag_o     word data and tag to install
//   refill_done_o           one-cycle pulse, block valid in cache
//   busy_o                  refill in progress (request, fill or drain)
module icache_refill_unit #(
   parameter int unsigned B = 64,
   parameter int unsigned S = 64
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     instr_hit_f_i,
   input  logic                                     ic_repl_permit_i,
   input  logic [31:0]                              pc_f_i,
   input  logic                                     abort_i,
   output logic                                     mem_req_o,
   output logic [31:0]                              mem_addr_o,
   input  logic                                     mem_ready_i,
   input  logic                                     mem_rvalid_i,
   input  logic [31:0]                              mem_rdata_i,
   output logic                                     refill_we_o,
   output logic [$clog2(S)-1:0]                     refill_set_o,
   output logic [$clog2(B/4)-1:0]                   refill_word_o,
   output logic [31:0]                              refill_data_o,
   output logic [32-$clog2(S)-$clog2(B)-1:0]        refill_tag_o,
   output logic                                     refill_done_o,
   output logic                                     busy_o
);

   localparam int unsigned WORDS = B / 4;
   localparam int unsigned OffW  = $clog2(B);
   localparam int unsigned SetW  = $clog2(S);
   localparam int unsigned WordW = $clog2(WORDS);
   localparam int unsigned BlkW  = 32 - OffW;

   typedef enum logic [2:0] {StIdle, StReq, StFill, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [WordW-1:0]   cnt_q, cnt_d;
   // Block number {tag, set}; the byte offset is always zero so it is not stored.
   logic [BlkW-1:0]    blk_q, blk_d;

   logic               start;
   logic               last_beat;
   logic               beat;
   logic               unused_off;

   assign unused_off = ^pc_f_i[OffW-1:0];

   assign start     = !instr_hit_f_i && ic_repl_permit_i && !abort_i;
   assign last_beat = (cnt_q == WordW'(WORDS - 1));
   assign beat      = ((state_q == StFill) || (state_q == StDrain)) && mem_rvalid_i;

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StReq;
         end
         StReq: begin
            if (mem_ready_i) begin
               // Accepted burst must be consumed in full even if aborted.
               state_d = abort_i ? StDrain : StFill;
            end else if (abort_i) begin
               state_d = StIdle;
            end
         end
         StFill: begin
            if (abort_i) begin
               state_d = (mem_rvalid_i && last_beat) ? StIdle : StDrain;
            end else if (mem_rvalid_i && last_beat) begin
               state_d = StDone;
            end
         end
         StDrain: begin
            if (mem_rvalid_i && last_beat) state_d = StIdle;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      mem_req_o     = (state_q == StReq);
      mem_addr_o    = {blk_q, {OffW{1'b0}}};
      refill_we_o   = (state_q == StFill) && mem_rvalid_i && !abort_i;
      refill_word_o = cnt_q;
      refill_data_o = refill_we_o ? mem_rdata_i : 32'h0;
      refill_set_o  = blk_q[SetW-1:0];
      refill_tag_o  = blk_q[BlkW-1:SetW];
      refill_done_o = (state_q == StDone);
      busy_o        = (state_q == StReq) || (state_q == StFill) || (state_q == StDrain);
   end

   // Datapath next-state
   always_comb begin
      blk_d = blk_q;
      cnt_d = cnt_q;
      if ((state_q == StIdle) && start) begin
         blk_d = pc_f_i[31:OffW];
      end
      if ((state_q == StReq) && mem_ready_i) begin
         cnt_d = '0;
      end else if (beat && !last_beat) begin
         // Holds at the last index so the counter never wraps on its own.
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         blk_q <= '0;
         cnt_q <= '0;
      end else begin
         blk_q <= blk_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_icache_refill_unit.sv
module tb_icache_refill_unit;

   logic        clk;
   logic        reset_i;
   logic        instr_hit_f_i;
   logic        ic_repl_permit_i;
   logic [31:0] pc_f_i;
   logic        abort_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        refill_we_o;
   logic [5:0]  refill_set_o;
   logic [3:0]  refill_word_o;
   logic [31:0] refill_data_o;
   logic [19:0] refill_tag_o;
   logic        refill_done_o;
   logic        busy_o;

   int tests_run = 0;
   int tests_failed = 0;

   icache_refill_unit #(
      .B(64),
      .S(64)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .instr_hit_f_i    (instr_hit_f_i),
      .ic_repl_permit_i (ic_repl_permit_i),
      .pc_f_i           (pc_f_i),
      .abort_i          (abort_i),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_ready_i      (mem_ready_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_rdata_i      (mem_rdata_i),
      .refill_we_o      (refill_we_o),
      .refill_set_o     (refill_set_o),
      .refill_word_o    (refill_word_o),
      .refill_data_o    (refill_data_o),
      .refill_tag_o     (refill_tag_o),
      .refill_done_o    (refill_done_o),
      .busy_o           (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Moves to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"},  32'(mem_req_o), 32'h0);
      chk({tag, "_addr"}, mem_addr_o, 32'h0);
      chk({tag, "_we"},   32'(refill_we_o), 32'h0);
      chk({tag, "_set"},  32'(refill_set_o), 32'h0);
      chk({tag, "_word"}, 32'(refill_word_o), 32'h0);
      chk({tag, "_data"}, refill_data_o, 32'h0);
      chk({tag, "_tag"},  32'(refill_tag_o), 32'h0);
      chk({tag, "_done"}, 32'(refill_done_o), 32'h0);
      chk({tag, "_busy"}, 32'(busy_o), 32'h0);
   endtask

   initial begin
      reset_i          = 1'b0;
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      pc_f_i           = 32'h0;
      abort_i          = 1'b0;
      mem_ready_i      = 1'b0;
      mem_rvalid_i     = 1'b0;
      mem_rdata_i      = 32'h0;

      // Reset state
      #3;
      check_all_zero("reset");
      #9;
      reset_i = 1'b1;
      tick();

      // Basic refill: pc 0x1234 -> block 0x1200, set 0x08, tag 0x1
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b1;
      pc_f_i           = 32'h0000_1234;
      mem_ready_i      = 1'b1;
      #1;
      chk("idle_req", 32'(mem_req_o), 32'h0);
      tick();                                   // cycle 1: request
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      #1;
      chk("basic_req",  32'(mem_req_o), 32'h1);
      chk("basic_addr", mem_addr_o, 32'h0000_1200);
      chk("basic_set",  32'(refill_set_o), 32'h08);
      chk("basic_tag",  32'(refill_tag_o), 32'h1);
      chk("basic_busy", 32'(busy_o), 32'h1);
      tick();                                   // cycle 2: first beat
      mem_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 32'hA0 + 32'(i);
         #1;
         chk("basic_we",   32'(refill_we_o), 32'h1);
         chk("basic_word", 32'(refill_word_o), 32'(i));
         chk("basic_data", refill_data_o, 32'hA0 + 32'(i));
         chk("basic_nodone", 32'(refill_done_o), 32'h0);
         tick();
      end
      // Cycle 18: done pulse; a miss here must not be accepted
      mem_rvalid_i     = 1'b0;
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b1;
      pc_f_i           = 32'h0001_F7C0;
      #1;
      chk("basic_done", 32'(refill_done_o), 32'h1);
      chk("done_busy",  32'(busy_o), 32'h0);
      chk("done_req",   32'(mem_req_o), 32'h0);
      tick();
      #1;
      chk("after_done",     32'(refill_done_o), 32'h0);
      chk("done_no_accept", 32'(mem_req_o), 32'h0);
      tick();                                   // miss accepted from idle

      // Request backpressure: block 0x1F7C0, set 0x1F, tag 0x1F
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      mem_ready_i      = 1'b0;
      mem_rvalid_i     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_req",  32'(mem_req_o), 32'h1);
         chk("bp_addr", mem_addr_o, 32'h0001_F7C0);
         chk("bp_busy", 32'(busy_o), 32'h1);
         chk("bp_we",   32'(refill_we_o), 32'h0);
         tick();
      end
      mem_ready_i  = 1'b1;
      mem_rvalid_i = 1'b0;
      #1;
      chk("bp_set", 32'(refill_set_o), 32'h1F);
      chk("bp_tag", 32'(refill_tag_o), 32'h1F);
      chk("bp_acc_we", 32'(refill_we_o), 32'h0);
      tick();
      mem_ready_i = 1'b0;

      // Gapped data: valid, idle, idle, valid ...
      for (int i = 0; i < 16; i++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 32'hB0 + 32'(i);
         #1;
         chk("gap_we",   32'(refill_we_o), 32'h1);
         chk("gap_word", 32'(refill_word_o), 32'(i));
         chk("gap_data", refill_data_o, 32'hB0 + 32'(i));
         tick();
         if (i < 15) begin
            for (int g = 0; g < 2; g++) begin
               mem_rvalid_i = 1'b0;
               #1;
               chk("gap_idle_we", 32'(refill_we_o), 32'h0);
               chk("gap_idle_done", 32'(refill_done_o), 32'h0);
               tick();
            end
         end
      end
      mem_rvalid_i = 1'b0;
      #1;
      chk("gap_done", 32'(refill_done_o), 32'h1);
      tick();

      // Abort mid-fill at beat 5: pc 0x40 -> set 1, tag 0
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b1;
      pc_f_i           = 32'h0000_0040;
      tick();
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      mem_ready_i      = 1'b1;
      #1;
      chk("ab_addr", mem_addr_o, 32'h0000_0040);
      chk("ab_set",  32'(refill_set_o), 32'h01);
      tick();
      mem_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 32'hC0 + 32'(i);
         abort_i      = (i == 5);
         #1;
         chk("ab_we",   32'(refill_we_o), (i < 5) ? 32'h1 : 32'h0);
         chk("ab_busy", 32'(busy_o), 32'h1);
         chk("ab_done", 32'(refill_done_o), 32'h0);
         tick();
      end
      // Idle after beat 15; a new miss starts a request next cycle
      abort_i          = 1'b0;
      mem_rvalid_i     = 1'b0;
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b1;
      #1;
      chk("ab_idle_busy", 32'(busy_o), 32'h0);
      chk("ab_idle_done", 32'(refill_done_o), 32'h0);
      tick();
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      #1;
      chk("ab_new_req", 32'(mem_req_o), 32'h1);

      // Abort in request before acceptance
      abort_i = 1'b1;
      #1;
      chk("rq_ab_req_held", 32'(mem_req_o), 32'h1);
      tick();
      abort_i      = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      chk("rq_ab_req",  32'(mem_req_o), 32'h0);
      chk("rq_ab_busy", 32'(busy_o), 32'h0);
      chk("rq_ab_we",   32'(refill_we_o), 32'h0);
      mem_rvalid_i = 1'b0;
      tick();

      // Abort coincident with acceptance: full burst drained silently
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b1;
      tick();
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      mem_ready_i      = 1'b1;
      abort_i          = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      abort_i     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_rvalid_i = 1'b1;
         #1;
         chk("acc_ab_busy", 32'(busy_o), 32'h1);
         chk("acc_ab_we",   32'(refill_we_o), 32'h0);
         tick();
      end
      mem_rvalid_i = 1'b0;
      #1;
      chk("acc_ab_idle", 32'(busy_o), 32'h0);
      chk("acc_ab_done", 32'(refill_done_o), 32'h0);

      // No permit / hit / abort-blocked start
      instr_hit_f_i    = 1'b0;
      ic_repl_permit_i = 1'b0;
      tick();
      #1;
      chk("nopermit_req",  32'(mem_req_o), 32'h0);
      chk("nopermit_busy", 32'(busy_o), 32'h0);
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b1;
      tick();
      #1;
      chk("hit_req",  32'(mem_req_o), 32'h0);
      chk("hit_busy", 32'(busy_o), 32'h0);
      instr_hit_f_i = 1'b0;
      abort_i       = 1'b1;
      tick();
      #1;
      chk("abort_start_req", 32'(mem_req_o), 32'h0);
      abort_i = 1'b0;

      // Async reset during fill
      pc_f_i = 32'h0000_1234;
      tick();
      instr_hit_f_i    = 1'b1;
      ic_repl_permit_i = 1'b0;
      mem_ready_i      = 1'b1;
      tick();
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hD0;
      tick();
      tick();
      #1;
      chk("rst_pre_we",   32'(refill_we_o), 32'h1);
      chk("rst_pre_word", 32'(refill_word_o), 32'h2);
      reset_i = 1'b0;
      #1;
      check_all_zero("rst_fill");
      mem_rvalid_i = 1'b0;
      #1;
      reset_i = 1'b1;
      tick();
      #1;
      chk("rst_after_busy", 32'(busy_o), 32'h0);
      chk("rst_after_req",  32'(mem_req_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
